// File: rtl/const_imm_fetch.sv
// const_imm_fetch: decodes i32/i64/f32/f64.const immediates from the code byte stream
// Ports: clk; reset (sync, active-low); start/opcode begin a decode in IDLE;
// in_data/in_valid/in_ready byte stream; result/result_type/out_valid/out_ready typed
// output handshake; busy = not IDLE; trap 0 none, 1 bad opcode, 2 LEB overlong, 3 LEB bad final bits.
module const_imm_fetch #(
    parameter int RESULT_W   = 64,
    parameter bit STRICT_LEB = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          opcode,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [RESULT_W-1:0] result,
    output logic [1:0]          result_type,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic [2:0]          trap
);
    typedef enum logic [2:0] {IDLE, LEB, FIXED, DONE, ERR} state_t;
    state_t      state;
    logic [63:0] acc;
    logic [3:0]  cnt;
    logic [1:0]  typ;
    logic [2:0]  trap_q;
    logic        is64, last, fin_ok, op_ok;
    logic [3:0]  last_n;
    logic [6:0]  sh7;
    logic [63:0] leb_bits, fill, mask, leb_next, fix_next;
    assign is64   = typ[0];
    assign last_n = typ[1] ? (is64 ? 4'd7 : 4'd3) : (is64 ? 4'd9 : 4'd4);
    assign last   = cnt == last_n;
    assign sh7    = 7'(cnt) * 7'd7;
    assign leb_bits = {57'b0, in_data[6:0]} << sh7;
    // sign-fill everything above this group; shifts of 64+ leave nothing to fill
    assign fill     = in_data[6] ? ({64{1'b1}} << (sh7 + 7'd7)) : 64'b0;
    assign mask     = is64 ? {64{1'b1}} : 64'h0000_0000_ffff_ffff;
    assign leb_next = (acc | leb_bits | (in_data[7] ? 64'b0 : fill)) & mask;
    assign fix_next = acc | ({56'b0, in_data} << {cnt[2:0], 3'b000});
    // bits of the last group beyond the type width must repeat the value's sign bit
    assign fin_ok = is64 ? (in_data[6:0] == 7'h00 || in_data[6:0] == 7'h7f)
                         : (in_data[6:3] == 4'h0 || in_data[6:3] == 4'hf);
    assign op_ok  = opcode == 8'h41 || opcode == 8'h43 ||
                    (RESULT_W == 64 && (opcode == 8'h42 || opcode == 8'h44));
    assign in_ready    = state == LEB || state == FIXED;
    assign out_valid   = state == DONE;
    assign busy        = state != IDLE;
    assign trap        = trap_q;
    assign result      = acc[RESULT_W-1:0];
    assign result_type = typ;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            typ    <= '0;
            trap_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc <= '0;
                    cnt <= '0;
                    if (op_ok) begin
                        typ   <= opcode[1:0] - 2'd1;
                        state <= (opcode == 8'h41 || opcode == 8'h42) ? LEB : FIXED;
                    end else begin
                        trap_q <= 3'd1;
                        state  <= ERR;
                    end
                end
                LEB: if (in_valid) begin
                    acc <= leb_next;
                    cnt <= cnt + 4'd1;
                    if (last && in_data[7]) begin
                        trap_q <= 3'd2;
                        state  <= ERR;
                    end else if (!in_data[7]) begin
                        if (last && STRICT_LEB && !fin_ok) begin
                            trap_q <= 3'd3;
                            state  <= ERR;
                        end else state <= DONE;
                    end
                end
                FIXED: if (in_valid) begin
                    acc <= fix_next;
                    cnt <= cnt + 4'd1;
                    if (last) state <= DONE;
                end
                DONE: if (out_ready) state <= IDLE;
                default: ;
            endcase
        end
    end
endmodule
